// File: rtl/port_a_arbiter.sv
// Port-A arbiter: VGA reads win over FIFO-buffered input writes; a starvation counter forces a write after STARVE_MAX reads.
// Grant to mem_* takes 1 cycle and read data returns 2 cycles after the strobe; in_ready drops only when the FIFO is full.
module port_a_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 enable_i,
  input  logic                                 vga_req_i,
  input  logic [14:0]                          vga_addr_i,
  output logic                                 vga_ack_o,
  output logic                                 vga_rvalid_o,
  output logic [15:0]                          vga_rdata_o,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [23:0]                          in_addr_i,
  input  logic [15:0]                          in_data_i,
  output logic                                 mem_en_o,
  output logic                                 mem_we_o,
  output logic [23:0]                          mem_addr_o,
  output logic [15:0]                          mem_din_o,
  input  logic [15:0]                          mem_dout_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [23:0]   fifo_addr_q [FIFO_DEPTH];
  logic [15:0]   fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          mem_en_q, mem_we_q;
  logic [23:0]   mem_addr_q;
  logic [15:0]   mem_din_q;
  logic          vga_ack_q;
  logic          rd_pend_q;
  logic          rvalid_q;
  logic [15:0]   rdata_q;

  logic fifo_empty, fifo_full, push, pop, grant_rd, grant_wr;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign in_ready_o = reset_i && !fifo_full;
  assign push       = in_valid_i && in_ready_o;

  // VGA keeps priority until the starvation counter saturates with a write waiting.
  assign grant_rd = enable_i && vga_req_i && (fifo_empty || (starve_q < SW'(STARVE_MAX)));
  assign grant_wr = enable_i && !grant_rd && !fifo_empty;
  assign pop      = grant_wr;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (enable_i) begin
      if (grant_wr || fifo_empty) begin
        starve_d = '0;
      end else if (grant_rd && (starve_q != SW'(STARVE_MAX))) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= in_addr_i;
      fifo_data_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      starve_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      vga_ack_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      level_q  <= level_d;
      starve_q <= starve_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      mem_en_q  <= grant_rd || grant_wr;
      mem_we_q  <= grant_wr;
      vga_ack_q <= grant_rd;
      if (grant_rd) begin
        mem_addr_q <= {9'b0, vga_addr_i};
      end else if (grant_wr) begin
        mem_addr_q <= fifo_addr_q[rd_ptr_q];
        mem_din_q  <= fifo_data_q[rd_ptr_q];
      end
      // Memory answers one cycle after the strobe; capture it on the following edge.
      rd_pend_q <= mem_en_q && !mem_we_q;
      rvalid_q  <= rd_pend_q;
      if (rd_pend_q) begin
        rdata_q <= mem_dout_i;
      end
    end
  end

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_din_o    = mem_din_q;
  assign vga_ack_o    = vga_ack_q;
  assign vga_rvalid_o = rvalid_q;
  assign vga_rdata_o  = rdata_q;
  assign fifo_level_o = level_q;

endmodule
